// File: rtl/adc_glue_pkg.sv
// rtl/adc_glue_pkg.sv - shared types and defaults for the ADC capture glue
//
// Holds the frame aligner state enum and the lane geometry defaults that the
// ISERDES wrapper, frame aligner and capture stages all agree on.
package adc_glue_pkg;

    // Number of ADC data lanes and bits per deserialized lane word.
    localparam int unsigned ADC_LANES = 8;
    localparam int unsigned ADC_SER_W = 8;

    // Frame-clock lane value seen when the word boundary is correct.
    localparam logic [7:0] ADC_FRAME_PATTERN = 8'hF0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        SLIP   = 3'd2,
        SETTLE = 3'd3,
        LOCKED = 3'd4
    } align_state_t;

endpackage

// File: rtl/adc_frame_aligner_if.sv
// rtl/adc_frame_aligner_if.sv - deserialized lane bus into and out of the frame aligner
//
// Signals:
//   fclk_word  SER_W        deserialized frame-clock lane
//   lane_word  LANES*SER_W  deserialized data lanes, lane 0 in the LSBs
//   m_data     LANES*SER_W  registered data lanes towards capture
//   m_valid    1            m_data qualified (aligner locked)
// Modports:
//   master  the aligner: consumes fclk_word/lane_word, produces m_data/m_valid
//   slave   the surrounding fabric: drives the lanes, consumes m_data/m_valid
interface adc_frame_aligner_if #(
    parameter int unsigned LANES = adc_glue_pkg::ADC_LANES,
    parameter int unsigned SER_W = adc_glue_pkg::ADC_SER_W
);

    logic [SER_W-1:0]       fclk_word;
    logic [LANES*SER_W-1:0] lane_word;
    logic [LANES*SER_W-1:0] m_data;
    logic                   m_valid;

    modport master (
        input  fclk_word,
        input  lane_word,
        output m_data,
        output m_valid
    );

    modport slave (
        output fclk_word,
        output lane_word,
        input  m_data,
        input  m_valid
    );

endinterface

// File: rtl/adc_sat_counter.sv
// rtl/adc_sat_counter.sv - saturating up-counter with synchronous clear
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   clr    in   clear to zero (wins over inc)
//   inc    in   count up by one unless already at MAX
//   count  out  WIDTH-bit count value
module adc_sat_counter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned MAX   = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_V)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/adc_frame_aligner.sv
// rtl/adc_frame_aligner.sv - ISERDES word aligner driven by the ADC frame-clock lane
//
// Pulses bitslip until the deserialized frame-clock word equals FRAME_PATTERN,
// declares lock after LOCK_COUNT consecutive matches, forwards the data lanes
// registered while locked, and drops lock after UNLOCK_COUNT consecutive
// mismatches.
//
// Ports:
//   clk           in   divided deserializer clock
//   rst_n         in   asynchronous active-low reset
//   realign       in   single-cycle request to restart alignment
//   bitslip       out  one-cycle pulse to every ISERDES BITSLIP input
//   locked        out  alignment achieved
//   align_fail    out  sticky: SER_W slips since reset/realign without lock
//   slip_count    out  total slips modulo SER_W
//   mismatch_cnt  out  saturating count of mismatch cycles while locked
//   bus           master modport: fclk_word/lane_word in, m_data/m_valid out
module adc_frame_aligner
    import adc_glue_pkg::*;
#(
    parameter int unsigned      LANES         = ADC_LANES,
    parameter int unsigned      SER_W         = ADC_SER_W,
    parameter logic [SER_W-1:0] FRAME_PATTERN = ADC_FRAME_PATTERN,
    parameter int unsigned      SETTLE_CYCLES = 4,
    parameter int unsigned      LOCK_COUNT    = 16,
    parameter int unsigned      UNLOCK_COUNT  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     realign,
    output logic                     bitslip,
    output logic                     locked,
    output logic                     align_fail,
    output logic [$clog2(SER_W)-1:0] slip_count,
    output logic [15:0]              mismatch_cnt,
    adc_frame_aligner_if.master      bus
);

    localparam int unsigned SLIP_W   = $clog2(SER_W);
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned MATCH_W  = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W   = $clog2(UNLOCK_COUNT + 1);
    localparam int unsigned SINCE_W  = $clog2(SER_W + 1);

    align_state_t state, state_d;

    logic [SETTLE_W-1:0]    settle_cnt;
    logic [MATCH_W-1:0]     match_cnt;
    logic [MISS_W-1:0]      miss_cnt;
    logic [SINCE_W-1:0]     slips_since;
    logic [LANES*SER_W-1:0] m_data_q;

    logic frame_match;
    logic settle_done;
    logic lock_hit;
    logic unlock_hit;
    logic enter_slip;
    logic settle_run;
    logic match_run;
    logic miss_run;
    logic mismatch_inc;

    assign frame_match = (bus.fclk_word == FRAME_PATTERN);
    assign settle_done = (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
    assign lock_hit    = frame_match && (match_cnt == MATCH_W'(LOCK_COUNT - 1));
    assign unlock_hit  = !frame_match && (miss_cnt == MISS_W'(UNLOCK_COUNT - 1));

    // realign overrides every transition, so all the run/strobe terms below
    // are gated by it and every counter falls back to zero.
    always_comb begin
        state_d = state;
        if (realign) begin
            state_d = SETTLE;
        end else begin
            unique case (state)
                IDLE, SETTLE: if (settle_done) state_d = CHECK;
                CHECK: begin
                    if (!frame_match) begin
                        state_d = SLIP;
                    end else if (lock_hit) begin
                        state_d = LOCKED;
                    end
                end
                SLIP:   state_d = SETTLE;
                LOCKED: if (unlock_hit) state_d = CHECK;
                default: state_d = IDLE;
            endcase
        end
    end

    // SLIP is only reachable from CHECK without realign, so this doubles as
    // "a slip pulse is being issued on this edge".
    assign enter_slip   = (state_d == SLIP);
    assign settle_run   = !realign && ((state == IDLE) || (state == SETTLE)) && !settle_done;
    assign match_run    = !realign && (state == CHECK) && frame_match && !lock_hit;
    assign miss_run     = !realign && (state == LOCKED) && !frame_match && !unlock_hit;
    assign mismatch_inc = !realign && (state == LOCKED) && !frame_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // bitslip/locked are decoded from the next state so they are registered
    // yet line up exactly with the SLIP/LOCKED state cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            slip_count <= '0;
            bitslip    <= 1'b0;
            locked     <= 1'b0;
            align_fail <= 1'b0;
            m_data_q   <= '0;
        end else begin
            settle_cnt <= settle_run ? settle_cnt + 1'b1 : '0;
            match_cnt  <= match_run  ? match_cnt + 1'b1  : '0;
            miss_cnt   <= miss_run   ? miss_cnt + 1'b1   : '0;
            bitslip    <= enter_slip;
            locked     <= (state_d == LOCKED);
            m_data_q   <= bus.lane_word;

            // Tracks the physical ISERDES bit position, so realign keeps it.
            if (enter_slip) begin
                slip_count <= (slip_count == SLIP_W'(SER_W - 1)) ? '0 : slip_count + 1'b1;
            end

            if (realign) begin
                align_fail <= 1'b0;
            end else if (enter_slip && (slips_since >= SINCE_W'(SER_W - 1))) begin
                align_fail <= 1'b1;
            end
        end
    end

    adc_sat_counter #(
        .WIDTH (SINCE_W),
        .MAX   (SER_W)
    ) u_slips_since (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (realign),
        .inc   (enter_slip),
        .count (slips_since)
    );

    adc_sat_counter #(
        .WIDTH (16),
        .MAX   (16'hFFFF)
    ) u_mismatch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (mismatch_inc),
        .count (mismatch_cnt)
    );

    assign bus.m_data  = m_data_q;
    assign bus.m_valid = locked;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// tb/tb_adc_frame_aligner.sv - self-checking bench for adc_frame_aligner
module tb_adc_frame_aligner;
    import adc_glue_pkg::*;

    localparam int unsigned LANES = 8;
    localparam int unsigned SER_W = 8;
    localparam logic [7:0]  FRAME = 8'hF0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       realign = 1'b0;
    logic       bitslip;
    logic       locked;
    logic       align_fail;
    logic [2:0] slip_count;
    logic [15:0] mismatch_cnt;

    adc_frame_aligner_if #(.LANES(LANES), .SER_W(SER_W)) bus ();

    adc_frame_aligner #(
        .LANES         (LANES),
        .SER_W         (SER_W),
        .FRAME_PATTERN (FRAME),
        .SETTLE_CYCLES (4),
        .LOCK_COUNT    (16),
        .UNLOCK_COUNT  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .realign      (realign),
        .bitslip      (bitslip),
        .locked       (locked),
        .align_fail   (align_fail),
        .slip_count   (slip_count),
        .mismatch_cnt (mismatch_cnt),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] sb_q[$];
    logic [63:0] exp_word;
    logic [7:0]  lane_seed = 8'd0;
    logic        rot_mode = 1'b0;
    logic        slip_now = 1'b0;
    int          slips = 0;
    int          last_slip = -1;
    int          min_gap = 1000;
    int          cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample at the falling edge, score m_data against the word
    // driven one cycle earlier, run the ISERDES slip model, drive new lanes.
    task automatic tick();
        @(negedge clk);
        slip_now = 1'b0;
        if (sb_q.size() != 0) begin
            exp_word = sb_q.pop_front();
            if (bus.m_valid) chk("m_data", bus.m_data, exp_word);
        end
        if (bitslip) begin
            slip_now = 1'b1;
            slips++;
            if (last_slip >= 0 && (cyc - last_slip) < min_gap) min_gap = cyc - last_slip;
            last_slip = cyc;
            if (rot_mode) bus.fclk_word = {bus.fclk_word[0], bus.fclk_word[SER_W-1:1]};
        end
        cyc++;
        lane_seed = lane_seed + 8'd1;
        for (int i = 0; i < LANES; i++) bus.lane_word[i*SER_W +: SER_W] = lane_seed + 8'(i);
        sb_q.push_back(bus.lane_word);
    endtask

    task automatic wait_lock(input string tag, input int limit);
        int g = 0;
        while (!locked && g < limit) begin
            tick();
            g++;
        end
        chk(tag, 64'(locked), 64'd1);
    endtask

    task automatic wait_slip(input string tag, input int limit);
        int g = 0;
        tick();
        while (!slip_now && g < limit) begin
            tick();
            g++;
        end
        chk(tag, 64'(slip_now), 64'd1);
    endtask

    // Asserts reset between clock edges and checks the outputs cleared at once.
    task automatic reset_mid(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_bitslip"},  64'(bitslip), 64'd0);
        chk({tag, "_locked"},   64'(locked), 64'd0);
        chk({tag, "_fail"},     64'(align_fail), 64'd0);
        chk({tag, "_slipcnt"},  64'(slip_count), 64'd0);
        chk({tag, "_mismatch"}, 64'(mismatch_cnt), 64'd0);
        chk({tag, "_mdata"},    bus.m_data, 64'd0);
        chk({tag, "_mvalid"},   64'(bus.m_valid), 64'd0);
        chk({tag, "_state"},    64'(dut.state), 64'(IDLE));
    endtask

    task automatic release_rst(input string tag);
        tick();
        rst_n = 1'b1;
        slips = 0;
        last_slip = -1;
        min_gap = 1000;
        chk({tag, "_state_rel"}, 64'(dut.state), 64'(IDLE));
    endtask

    logic [7:0] w;
    int         exp_slips;
    logic [2:0] sc_before;

    initial begin
        bus.fclk_word = FRAME;
        bus.lane_word = '0;

        // Reset state
        tick();
        tick();
        reset_mid("reset");
        release_rst("reset");

        // Aligned from reset: lock after SETTLE_CYCLES + LOCK_COUNT edges
        repeat (19) tick();
        chk("al_locked_19", 64'(locked), 64'd0);
        tick();
        chk("al_locked_20", 64'(locked), 64'd1);
        chk("al_mvalid",    64'(bus.m_valid), 64'd1);
        chk("al_no_slip",   64'(slips), 64'd0);
        repeat (8) tick();

        // Mismatch tolerance: 3 misses then a match keeps lock
        bus.fclk_word = 8'h0F;
        repeat (3) tick();
        bus.fclk_word = FRAME;
        tick();
        chk("mt_locked_3",   64'(locked), 64'd1);
        chk("mt_mismatch_3", 64'(mismatch_cnt), 64'd3);
        bus.fclk_word = 8'h0F;
        repeat (3) tick();
        chk("mt_locked_7",  64'(locked), 64'd1);
        tick();
        chk("mt_unlock",    64'(locked), 64'd0);
        chk("mt_mvalid",    64'(bus.m_valid), 64'd0);
        chk("mt_check",     64'(dut.state), 64'(CHECK));
        chk("mt_mismatch7", 64'(mismatch_cnt), 64'd7);
        bus.fclk_word = FRAME;
        repeat (15) tick();
        chk("mt_relock_15", 64'(locked), 64'd0);
        tick();
        chk("mt_relock_16", 64'(locked), 64'd1);
        chk("mt_no_slip",   64'(slips), 64'd0);

        // Reset during SETTLE
        bus.fclk_word = 8'hAA;
        wait_slip("rs_slip_seen", 100);
        tick();
        chk("rs_in_settle", 64'(dut.state), 64'(SETTLE));
        reset_mid("rst_settle");
        release_rst("rst_settle");

        // Reset during SLIP
        wait_slip("rp_slip_seen", 100);
        reset_mid("rst_slip");

        // Bitslip recovery: the model moves the frame word one bit per slip
        w = 8'h87;
        exp_slips = 0;
        while (w != FRAME && exp_slips < 8) begin
            w = {w[0], w[7:1]};
            exp_slips++;
        end
        bus.fclk_word = 8'h87;
        rot_mode = 1'b1;
        release_rst("rst_rec");
        wait_lock("rec_lock", 300);
        chk("rec_slips",     64'(slips), 64'(exp_slips));
        chk("rec_slip_cnt",  64'(slip_count), 64'(exp_slips));
        chk("rec_gap_min6",  64'(min_gap >= 6), 64'd1);
        chk("rec_fail",      64'(align_fail), 64'd0);
        rot_mode = 1'b0;

        // Never matches: align_fail on the 8th slip, slip_count wraps
        tick();
        reset_mid("rst_nm");
        bus.fclk_word = 8'hAA;
        release_rst("rst_nm");
        for (int n = 1; n <= 10; n++) begin
            wait_slip("nm_slip_seen", 100);
            if (n == 7) begin
                chk("nm_fail_7",   64'(align_fail), 64'd0);
                chk("nm_slipcnt7", 64'(slip_count), 64'd7);
            end
            if (n == 8) begin
                chk("nm_fail_8",   64'(align_fail), 64'd1);
                chk("nm_slipcnt8", 64'(slip_count), 64'd0);
            end
            if (n == 10) begin
                chk("nm_fail_10",   64'(align_fail), 64'd1);
                chk("nm_slipcnt10", 64'(slip_count), 64'd2);
                chk("nm_locked",    64'(locked), 64'd0);
            end
        end
        chk("nm_gap_min6", 64'(min_gap >= 6), 64'd1);

        // Realign while locked with align_fail set
        bus.fclk_word = FRAME;
        wait_lock("ra_lock", 100);
        chk("ra_fail_pre", 64'(align_fail), 64'd1);
        sc_before = slip_count;
        realign = 1'b1;
        tick();
        realign = 1'b0;
        chk("ra_locked",  64'(locked), 64'd0);
        chk("ra_fail",    64'(align_fail), 64'd0);
        chk("ra_slipcnt", 64'(slip_count), 64'(sc_before));
        chk("ra_settle",  64'(dut.state), 64'(SETTLE));
        repeat (19) tick();
        chk("ra_relock_19", 64'(locked), 64'd0);
        tick();
        chk("ra_relock_20", 64'(locked), 64'd1);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
